// File: rtl/button_conditioner.sv
// Multi-channel pushbutton front end: two-flop synchroniser, tick-sampled debounce
// counter per channel, and a registered one-cycle pulse on each accepted press.
module button_conditioner #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 4,
  localparam int CNT_W       = $clog2(STABLE_TICKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pulse,
  output logic             any_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync;
  logic [N_BTN-1:0] level_d;
  logic [CNT_W-1:0] cnt [N_BTN];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a  <= '0;
      sync    <= '0;
      level   <= '0;
      level_d <= '0;
      pulse   <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      sync_a  <= btn_in;
      sync    <= sync_a;
      level_d <= level;
      pulse   <= level & ~level_d;
      if (tick) begin
        for (int i = 0; i < N_BTN; i++) begin
          // Any sample agreeing with the current level throws away partial progress.
          if (sync[i] == level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            level[i] <= sync[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign any_pulse = |pulse;

endmodule
